pipelined_data_memory: RTL and testbench

- Single-port word-addressed data memory for the processor datapath, successor to the basic data memory.
- Adds valid/ready request handshake, per-byte write enables, configurable read pipeline latency, and a hardware clear engine that zeroes every location after reset or on command.
- Sits between the load/store unit and the memory array; the load/store unit must honour req_ready.

---
 rtl/pipelined_data_memory.sv | 190 +++++++++++++++++++
 tb/tb_pipelined_data_memory.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_data_memory.sv
// rtl/pipelined_data_memory.sv - handshaked data memory with byte enables, LAT-cycle read pipe, clear engine; DMEM_PARITY_EN adds per-byte parity
module pipelined_data_memory #(
    parameter int D   = 6,
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear_start,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [D-1:0]   req_addr,
    input  logic [W-1:0]   req_wdata,
    input  logic [W/8-1:0] req_be,
    output logic           resp_valid,
    output logic [W-1:0]   resp_rdata,
    output logic           busy
`ifdef DMEM_PARITY_EN
    ,
    output logic           parity_err
`endif
);

    localparam int NB    = W / 8;
    localparam int DEPTH = 2 ** D;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [D:0]     cnt_q, cnt_d;
    logic           clr_we;

    logic [W-1:0]   mem_q [DEPTH];

    logic           mem_we;
    logic [D-1:0]   mem_waddr;
    logic [W-1:0]   mem_wdata;
    logic [NB-1:0]  mem_bmask;

    logic           accept, wr_acc, rd_acc;

    logic [W-1:0]   pipe_data_q [LAT];
    logic [W-1:0]   pipe_data_d [LAT];
    logic [LAT-1:0] pipe_valid_q, pipe_valid_d;

`ifdef DMEM_PARITY_EN
    logic [NB-1:0]  par_q [DEPTH];
    logic [LAT-1:0] pipe_err_q, pipe_err_d;

    function automatic logic [NB-1:0] byte_par(input logic [W-1:0] w);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) begin
            p[b] = ^w[8*b +: 8];
        end
        return p;
    endfunction
`endif

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_CLEAR);
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_write;
    assign rd_acc    = accept && !req_write;

    // Clear-engine FSM: sweep every word in CLEAR, wait for requests or clear_start in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == (D+1)'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Single write port shared by the clear sweep and accepted writes (never both at once)
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        mem_bmask = req_be;
        if (!reset) begin
            if (clr_we) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[D-1:0];
                mem_wdata = '0;
                mem_bmask = '1;
            end else if (wr_acc) begin
                mem_we    = 1'b1;
            end
        end
    end

    // Read pipeline: stage 0 samples the array at acceptance, data stages only move on valid so the output holds
    always_comb begin
        for (int i = 0; i < LAT; i++) begin
            pipe_data_d[i] = pipe_data_q[i];
        end
        pipe_valid_d    = '0;
        pipe_valid_d[0] = rd_acc;
        if (rd_acc) begin
            pipe_data_d[0] = mem_q[req_addr];
        end
        for (int i = 1; i < LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            if (pipe_valid_q[i-1]) begin
                pipe_data_d[i] = pipe_data_q[i-1];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    // Parity check travels alongside the read data
    always_comb begin
        pipe_err_d = pipe_err_q;
        if (rd_acc) begin
            pipe_err_d[0] = |(par_q[req_addr] ^ byte_par(mem_q[req_addr]));
        end
        for (int i = 1; i < LAT; i++) begin
            if (pipe_valid_q[i-1]) begin
                pipe_err_d[i] = pipe_err_q[i-1];
            end
        end
    end

    assign parity_err = pipe_valid_q[LAT-1] && pipe_err_q[LAT-1];
`endif

    assign resp_valid = pipe_valid_q[LAT-1];
    assign resp_rdata = pipe_data_q[LAT-1];

    // Memory array with byte-masked writes; contents are not reset, the clear sweep zeroes them
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_bmask[b]) begin
                    mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
                    par_q[mem_waddr][b] <= ^mem_wdata[8*b +: 8];
`endif
                end
            end
        end
    end

    // Control and pipeline registers; reset flushes in-flight reads and restarts the sweep at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            pipe_valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
`ifdef DMEM_PARITY_EN
            pipe_err_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < LAT; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
`ifdef DMEM_PARITY_EN
            pipe_err_q   <= pipe_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_data_memory.sv
// tb/tb_pipelined_data_memory.sv - LAT=1 and LAT=3 instances driven in lockstep and checked against a behavioural model
module tb_pipelined_data_memory;

    logic        clk = 1'b0;
    logic        reset, clear_start, req_valid, req_write;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        ready1, rv1, busy1, ready3, rv3, busy3;
    logic [31:0] rd1, rd3;
    logic        perr1, perr3;

    always #5 clk = ~clk;

    pipelined_data_memory #(.D(6), .W(32), .LAT(1)) u1 (
        .clk(clk), .reset(reset), .clear_start(clear_start),
        .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv1), .resp_rdata(rd1), .busy(busy1)
`ifdef DMEM_PARITY_EN
        , .parity_err(perr1)
`endif
    );

    pipelined_data_memory #(.D(6), .W(32), .LAT(3)) u3 (
        .clk(clk), .reset(reset), .clear_start(clear_start),
        .req_valid(req_valid), .req_ready(ready3), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(rv3), .resp_rdata(rd3), .busy(busy3)
`ifdef DMEM_PARITY_EN
        , .parity_err(perr3)
`endif
    );

`ifndef DMEM_PARITY_EN
    assign perr1 = 1'b0;
    assign perr3 = 1'b0;
`endif

    typedef struct {
        int          edge_n;
        logic [31:0] data;
        logic        perr;
    } rsp_t;

    rsp_t        q1[$];
    rsp_t        q3[$];
    logic [31:0] mdl [64];
    logic [31:0] last1, last3;
    int          n = 0;
    int          origin = 0;
    int          flip_addr = -1;
    int          checks = 0;
    int          fails = 0;

    function automatic bit mdl_ready();
        return (n - origin) >= 64;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic mdl_zero();
        for (int a = 0; a < 64; a++) mdl[a] = 32'h0;
        flip_addr = -1;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare every output
    task automatic cycle();
        bit   acc, clr, ev1, ev3;
        logic ep1, ep3;
        rsp_t r;
        acc = !reset && req_valid && mdl_ready();
        clr = !reset && clear_start && mdl_ready();
        @(posedge clk);
        n++;
        if (reset) begin
            origin = n;
            q1.delete();
            q3.delete();
            last1 = 32'h0;
            last3 = 32'h0;
            mdl_zero();
        end else begin
            if (acc) begin
                if (req_write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_be[b]) mdl[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                    if (int'(req_addr) == flip_addr && req_be[0]) flip_addr = -1;
                end else begin
                    r.edge_n = n;
                    r.data   = mdl[req_addr];
                    r.perr   = (int'(req_addr) == flip_addr);
                    q1.push_back(r);
                    r.perr   = 1'b0;
                    q3.push_back(r);
                end
            end
            if (clr) begin
                origin = n;
                mdl_zero();
            end
        end
        #1;
        ev1 = 0; ep1 = 0;
        if (q1.size() > 0 && q1[0].edge_n == n) begin
            ev1 = 1; last1 = q1[0].data; ep1 = q1[0].perr; void'(q1.pop_front());
        end
        ev3 = 0; ep3 = 0;
        if (q3.size() > 0 && q3[0].edge_n + 2 == n) begin
            ev3 = 1; last3 = q3[0].data; ep3 = q3[0].perr; void'(q3.pop_front());
        end
        chk("busy1", busy1, !mdl_ready());
        chk("ready1", ready1, mdl_ready());
        chk("busy3", busy3, !mdl_ready());
        chk("ready3", ready3, mdl_ready());
        chk("rvalid1", rv1, ev1);
        chk("rdata1", rd1, last1);
        chk("rvalid3", rv3, ev3);
        chk("rdata3", rd3, last3);
`ifdef DMEM_PARITY_EN
        chk("perr1", perr1, ep1);
        chk("perr3", perr3, ep3);
`endif
    endtask

    task automatic idle(input int k);
        req_valid = 1'b0;
        repeat (k) cycle();
    endtask

    task automatic wait_ready();
        req_valid = 1'b0;
        for (int i = 0; i < 200 && !mdl_ready(); i++) cycle();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear_start = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        last1 = '0; last3 = '0;
        mdl_zero();

        cycle();
        reset = 1'b0;
        chk("rst_busy", busy1, 1'b1);
        chk("rst_rdata", rd1, 32'h0);
        idle(63);
        chk("clear_still_busy", ready1, 1'b0);
        idle(1);
        chk("clear_done_ready", ready1, 1'b1);

        rd(6'h3F);
        chk("rd3f_valid", rv1, 1'b1);
        chk("rd3f_data", rd1, 32'h0);

        wr(6'd5, 32'hDEADBEEF, 4'b1111);
        wr(6'd5, 32'h000000AA, 4'b0001);
        wr(6'd5, 32'hFFFFFFFF, 4'b0000);
        rd(6'd5);
        chk("byte_merge", rd1, 32'hDEADBEAA);

        wr(6'd1, 32'd10, 4'hF);
        wr(6'd2, 32'd20, 4'hF);
        wr(6'd3, 32'd30, 4'hF);
        rd(6'd1);
        chk("lat3_early", rv3, 1'b0);
        rd(6'd2);
        rd(6'd3);
        chk("lat3_r0", rd3, 32'd10);
        idle(1);
        chk("lat3_r1", rd3, 32'd20);
        idle(1);
        chk("lat3_r2", rd3, 32'd30);
        chk("lat3_r2v", rv3, 1'b1);
        idle(1);

        wr(6'd7, 32'h1234, 4'hF);
        clear_start = 1'b1;
        rd(6'd7);
        clear_start = 1'b0;
        chk("clr_read", rd1, 32'h1234);
        chk("clr_busy", busy1, 1'b1);
        clear_start = 1'b1;
        idle(10);
        clear_start = 1'b0;
        wait_ready();
        rd(6'd7);
        chk("clr_zeroed", rd1, 32'h0);

        wr(6'd4, 32'hCAFEF00D, 4'hF);
        rd(6'd4);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_flush3", rv3, 1'b0);
        idle(3);
        chk("rst_flush3_late", rv3, 1'b0);
        wait_ready();
        rd(6'd4);
        chk("rst_clears", rd1, 32'h0);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            if (mdl_ready()) begin
                req_valid   = ($urandom_range(0, 3) != 0);
                req_write   = $urandom_range(0, 1) == 1;
                req_addr    = 6'($urandom_range(0, 15));
                req_wdata   = $urandom;
                req_be      = 4'($urandom_range(0, 15));
                clear_start = ($urandom_range(0, 79) == 0);
            end else begin
                clear_start = ($urandom_range(0, 3) == 0);
            end
            cycle();
        end
        clear_start = 1'b0;
        idle(4);

`ifdef DMEM_PARITY_EN
        wait_ready();
        wr(6'd9, 32'h55AA33CC, 4'hF);
        wr(6'd8, 32'h01020304, 4'hF);
        u1.par_q[9][0] = ~u1.par_q[9][0];
        flip_addr = 9;
        rd(6'd9);
        chk("perr_hit", perr1, 1'b1);
        rd(6'd8);
        chk("perr_clean", perr1, 1'b0);
        idle(4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
